vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_axis_counter.sv | 36 +++
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator.
// Holds the default 640x480@60 timing constants, the pattern-mode enum
// and the helpers that derive the total line/frame lengths.
package vga_pkg;

   localparam int DEF_H_ACTIVE    = 640;
   localparam int DEF_H_FP        = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BP        = 48;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_FP        = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BP        = 33;
   localparam int DEF_SYNC_POL    = 1;
   localparam int DEF_SCALE_SHIFT = 4;
   localparam int DEF_COLOR_W     = 1;
   localparam int DEF_CW          = 10;

   typedef enum logic [1:0] {
      MODE_OVERLAY = 2'd0,
      MODE_BARS    = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_WHITE   = 2'd3
   } mode_e;

   function automatic int h_total(int sync, int bp, int act, int fp);
      return sync + bp + act + fp;
   endfunction

   function automatic int v_total(int sync, int bp, int act, int fp);
      return sync + bp + act + fp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video bus between a pattern/timing source and its consumer.
//   master : drives en (pixel tick), mode, overlay_in; receives video.
//   slave  : the timing generator; receives controls, drives coordinates,
//            syncs, RGB, data-enable and the line/frame start pulses.
interface vga_timing_gen_if
   import vga_pkg::*;
#(
   parameter int CW          = DEF_CW,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int COLOR_W     = DEF_COLOR_W
);
   logic                    en;
   logic [1:0]              mode;
   logic                    overlay_in;
   logic [CW-SCALE_SHIFT-1:0] x_div;
   logic [CW-SCALE_SHIFT-1:0] y_div;
   logic                    o_hsync;
   logic                    o_vsync;
   logic [COLOR_W-1:0]      o_red;
   logic [COLOR_W-1:0]      o_green;
   logic [COLOR_W-1:0]      o_blue;
   logic                    active;
   logic                    line_start;
   logic                    frame_start;

   modport master (
      output en, mode, overlay_in,
      input  x_div, y_div, o_hsync, o_vsync, o_red, o_green, o_blue,
             active, line_start, frame_start
   );

   modport slave (
      input  en, mode, overlay_in,
      output x_div, y_div, o_hsync, o_vsync, o_red, o_green, o_blue,
             active, line_start, frame_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical).
// Ports: clk, rst (sync, active-high), step (advance by one);
//        count (0..TOTAL-1), in_sync (count < SYNC),
//        in_active (count in [START, START+LEN-1]),
//        wrap (step on the last count, i.e. the counter returns to 0 now).
module vga_axis_counter #(
   parameter int CW    = 10,
   parameter int TOTAL = 800,
   parameter int SYNC  = 96,
   parameter int START = 144,
   parameter int LEN   = 640
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          in_sync,
   output logic          in_active,
   output logic          wrap
);
   localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
   localparam logic [CW-1:0] ACT_BEG  = CW'(START);
   localparam logic [CW-1:0] ACT_END  = CW'(START + LEN);

   assign wrap      = step && (count == LAST);
   assign in_sync   = count < SYNC_END;
   assign in_active = (count >= ACT_BEG) && (count < ACT_END);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (step)
         count <= wrap ? '0 : count + CW'(1);
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing and test-pattern generator.
// Ports: clk, rst (sync, active-high), bus (slave side of vga_timing_gen_if).
// Stage 0 is the h/v counters plus the combinational scaled coordinates
// x_div/y_div; stage 1 registers syncs, RGB and active on each pixel tick.
// The pattern mode is captured only at the frame boundary so a frame is
// never drawn with two different patterns.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int SYNC_POL    = DEF_SYNC_POL,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int COLOR_W     = DEF_COLOR_W,
   parameter int CW          = DEF_CW
) (
   input logic              clk,
   input logic              rst,
   vga_timing_gen_if.slave  bus
);
   localparam int H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
   localparam int XW      = CW - SCALE_SHIFT;
   localparam logic [CW-1:0] H_START = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] V_START = CW'(V_SYNC + V_BP);
   localparam logic [CW-1:0] BAR_W   = CW'(H_ACTIVE / 8);
   localparam logic          POL     = 1'(SYNC_POL);

   logic [CW-1:0]      h, v;
   logic               h_sync, h_act, h_wrap;
   logic               v_sync, v_act, v_wrap;
   logic               in_win, chk;
   logic [CW-1:0]      x_act, y_act;
   logic [2:0]         bar;
   logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;
   mode_e              mode_q;

   vga_axis_counter #(
      .CW(CW), .TOTAL(H_TOTAL), .SYNC(H_SYNC), .START(H_SYNC + H_BP), .LEN(H_ACTIVE)
   ) u_h_cnt (
      .clk(clk), .rst(rst), .step(bus.en),
      .count(h), .in_sync(h_sync), .in_active(h_act), .wrap(h_wrap)
   );

   // The vertical axis steps once per completed line.
   vga_axis_counter #(
      .CW(CW), .TOTAL(V_TOTAL), .SYNC(V_SYNC), .START(V_SYNC + V_BP), .LEN(V_ACTIVE)
   ) u_v_cnt (
      .clk(clk), .rst(rst), .step(h_wrap),
      .count(v), .in_sync(v_sync), .in_active(v_act), .wrap(v_wrap)
   );

   assign in_win = h_act && v_act;
   assign x_act  = h - H_START;
   assign y_act  = v - V_START;

   assign bus.x_div = in_win ? XW'(x_act >> SCALE_SHIFT) : '0;
   assign bus.y_div = in_win ? XW'(y_act >> SCALE_SHIFT) : '0;

   assign bar = 3'(x_act / BAR_W);
   assign chk = bus.x_div[0] ^ bus.y_div[0];

   always_comb begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
      if (in_win) begin
         case (mode_q)
            MODE_OVERLAY: begin
               r_nxt = {COLOR_W{bus.overlay_in}};
               g_nxt = {COLOR_W{bus.overlay_in}};
               b_nxt = {COLOR_W{bus.overlay_in}};
            end
            MODE_BARS: begin
               r_nxt = {COLOR_W{bar[2]}};
               g_nxt = {COLOR_W{bar[1]}};
               b_nxt = {COLOR_W{bar[0]}};
            end
            MODE_CHECKER: begin
               r_nxt = {COLOR_W{chk}};
               g_nxt = {COLOR_W{chk}};
               b_nxt = {COLOR_W{chk}};
            end
            MODE_WHITE: begin
               r_nxt = '1;
               g_nxt = '1;
               b_nxt = '1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q          <= mode_e'(bus.mode);
         bus.o_hsync     <= ~POL;
         bus.o_vsync     <= ~POL;
         bus.o_red       <= '0;
         bus.o_green     <= '0;
         bus.o_blue      <= '0;
         bus.active      <= 1'b0;
         bus.line_start  <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         // Pulses are re-evaluated every clk so they never stretch across en=0.
         bus.line_start  <= bus.en && (h == '0);
         bus.frame_start <= bus.en && (h == '0) && (v == '0);
         // v_wrap is the last pixel tick of the frame.
         if (v_wrap)
            mode_q <= mode_e'(bus.mode);
         if (bus.en) begin
            bus.o_hsync <= h_sync ? POL : ~POL;
            bus.o_vsync <= v_sync ? POL : ~POL;
            bus.o_red   <= r_nxt;
            bus.o_green <= g_nxt;
            bus.o_blue  <= b_nxt;
            bus.active  <= in_win;
         end
      end
   end
endmodule
